// File: rtl/vc_egress_arbiter.sv
// Egress arbiter: merges four per-class FIFOs into one output FIFO using
// round-robin with a per-class burst limit and a two-stage read/push pipeline.
module vc_egress_arbiter #(
  parameter int DATA_W = 6,
  parameter int BURST  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            empty_i,
  input  logic [4*DATA_W-1:0]   data_in_i,
  input  logic                  almost_full_i,
  output logic [3:0]            pop_o,
  output logic                  push_o,
  output logic [DATA_W-1:0]     data_out_o,
  output logic [1:0]            out_class_o,
  output logic [1:0]            state_o
);

  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cur_q, cur_d;
  logic [CNT_W-1:0]  burstCnt_q, burstCnt_d;
  logic              v1_q;
  logic [1:0]        c1_q;
  logic              push_q;
  logic [DATA_W-1:0] dataOut_q;
  logic [1:0]        outClass_q;

  logic [3:0]        othersNonEmpty;
  logic              keepCur;
  logic              found;
  logic [1:0]        cand;
  logic [1:0]        sel;
  logic              anyReq;
  logic              popEn;
  logic [CNT_W-1:0]  burstSat;

  // Stay on the current class until its burst is used up, unless nobody else
  // is waiting; otherwise search forward from cur+1, wrapping back to cur.
  always_comb begin
    othersNonEmpty        = ~empty_i;
    othersNonEmpty[cur_q] = 1'b0;
    keepCur = ~empty_i[cur_q] &&
              ((burstCnt_q < BURST_MAX) || (othersNonEmpty == 4'b0000));
    sel   = cur_q;
    found = 1'b0;
    cand  = cur_q;
    if (!keepCur) begin
      for (int k = 1; k <= 4; k++) begin
        cand = cur_q + 2'(k);
        if (!found && !empty_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign anyReq = |(~empty_i);
  assign popEn  = anyReq & ~almost_full_i & ~reset;
  assign pop_o  = popEn ? (4'b0001 << sel) : 4'b0000;

  assign burstSat = (burstCnt_q == BURST_MAX) ? BURST_MAX : burstCnt_q + 1'b1;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = popEn ? SERVE : IDLE;
      SERVE: begin
        if (!anyReq)            state_d = IDLE;
        else if (almost_full_i) state_d = STALL;
        else                    state_d = SERVE;
      end
      STALL: begin
        if (!anyReq)             state_d = IDLE;
        else if (!almost_full_i) state_d = SERVE;
        else                     state_d = STALL;
      end
      default: state_d = IDLE;
    endcase
  end

  // The burst count carries across a stall so a resumed class only finishes
  // its remaining budget; IDLE already zeroed it, so a fresh start lands on 1.
  always_comb begin
    cur_d      = cur_q;
    burstCnt_d = burstCnt_q;
    if (popEn) begin
      cur_d      = sel;
      burstCnt_d = (sel == cur_q) ? burstSat : CNT_W'(1);
    end
    if (state_d == IDLE) begin
      burstCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= 2'd0;
      burstCnt_q <= '0;
      v1_q       <= 1'b0;
      c1_q       <= 2'd0;
      push_q     <= 1'b0;
      dataOut_q  <= '0;
      outClass_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      burstCnt_q <= burstCnt_d;
      v1_q       <= popEn;
      c1_q       <= sel;
      push_q     <= v1_q;
      if (v1_q) begin
        dataOut_q  <= data_in_i[int'(c1_q)*DATA_W +: DATA_W];
        outClass_q <= c1_q;
      end
    end
  end

  assign push_o      = push_q;
  assign data_out_o  = dataOut_q;
  assign out_class_o = outClass_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Directed bench for vc_egress_arbiter: a cycle table for the main flow plus
// hand-written sequences driven by a small word-count FIFO model.
module tb_vc_egress_arbiter;

  localparam int DATA_W = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          emptyIn;
  logic [4*DATA_W-1:0] dataIn;
  logic                almostFull;
  logic [3:0]          pop;
  logic                push;
  logic [DATA_W-1:0]   dataOut;
  logic [1:0]          outClass;
  logic [1:0]          state;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] base [4];
  int                cnt  [4];
  int                left [4];
  bit                autoEmpty;
  logic [3:0]        popSeen;

  typedef struct {
    logic [3:0]        empty;
    logic              af;
    logic [3:0]        expPop;
    logic              expPush;
    logic [DATA_W-1:0] expData;
    logic [1:0]        expClass;
    logic [1:0]        expState;
  } vec_t;

  vec_t vecs [30];

  always #5 clk = ~clk;

  vc_egress_arbiter #(.DATA_W(DATA_W), .BURST(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .empty_i      (emptyIn),
    .data_in_i    (dataIn),
    .almost_full_i(almostFull),
    .pop_o        (pop),
    .push_o       (push),
    .data_out_o   (dataOut),
    .out_class_o  (outClass),
    .state_o      (state)
  );

  task automatic checkOutput(input string nm, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic refreshEmpty();
    for (int i = 0; i < 4; i++) emptyIn[i] = (left[i] == 0);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      base[i] = DATA_W'(i * 16);
      left[i] = 0;
    end
    autoEmpty = 1'b0;
    dataIn    = '0;
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic af);
    if (!autoEmpty) emptyIn = e;
    almostFull = af;
    #1;
  endtask

  // Class FIFO model: a pop seen this cycle presents the next word after the edge.
  task automatic advance();
    popSeen = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (popSeen[i]) begin
        cnt[i]++;
        dataIn[i*DATA_W +: DATA_W] = base[i] + DATA_W'(cnt[i]);
        if (left[i] > 0) left[i]--;
      end
    end
    if (autoEmpty) refreshEmpty();
    @(negedge clk);
  endtask

  task automatic applyReset(input bit checkIt);
    reset = 1'b1;
    autoEmpty = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(4'b0000, 1'b0);
      if (checkIt) begin
        checkOutput("rst_pop", c, 8'(pop), 8'h00);
        if (c == 1) begin
          checkOutput("rst_push", c, 8'(push), 8'h00);
          checkOutput("rst_data", c, 8'(dataOut), 8'h00);
          checkOutput("rst_class", c, 8'(outClass), 8'h00);
          checkOutput("rst_state", c, 8'(state), 8'h00);
        end
      end
      advance();
    end
    reset = 1'b0;
    resetModel();
  endtask

  logic [3:0]        p5 [7];
  logic [DATA_W-1:0] d5 [4];
  logic [1:0]        c5 [4];

  initial begin
    reset      = 1'b1;
    emptyIn    = 4'b1111;
    almostFull = 1'b0;
    resetModel();
    @(negedge clk);

    // Reset held two cycles with every class non-empty
    applyReset(1'b1);

    //             empty    af    pop      push  data   cls   state
    vecs[0]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 6'h00, 2'd0, 2'd0};
    vecs[1]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 6'h00, 2'd0, 2'd1};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 6'h01, 2'd0, 2'd1};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0010, 1'b1, 6'h02, 2'd0, 2'd1};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0100, 1'b1, 6'h11, 2'd1, 2'd1};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0100, 1'b1, 6'h12, 2'd1, 2'd1};
    vecs[6]  = '{4'b0000, 1'b0, 4'b1000, 1'b1, 6'h21, 2'd2, 2'd1};
    vecs[7]  = '{4'b0000, 1'b0, 4'b1000, 1'b1, 6'h22, 2'd2, 2'd1};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0001, 1'b1, 6'h31, 2'd3, 2'd1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0001, 1'b1, 6'h32, 2'd3, 2'd1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0010, 1'b1, 6'h03, 2'd0, 2'd1};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 6'h04, 2'd0, 2'd1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 6'h13, 2'd1, 2'd2};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 6'h13, 2'd1, 2'd2};
    vecs[14] = '{4'b0000, 1'b0, 4'b0010, 1'b0, 6'h13, 2'd1, 2'd2};
    vecs[15] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 6'h13, 2'd1, 2'd1};
    vecs[16] = '{4'b0100, 1'b0, 4'b1000, 1'b1, 6'h14, 2'd1, 2'd1};
    vecs[17] = '{4'b0110, 1'b0, 4'b1000, 1'b1, 6'h23, 2'd2, 2'd1};
    vecs[18] = '{4'b0110, 1'b0, 4'b0001, 1'b1, 6'h33, 2'd3, 2'd1};
    vecs[19] = '{4'b0111, 1'b0, 4'b1000, 1'b1, 6'h34, 2'd3, 2'd1};
    vecs[20] = '{4'b0111, 1'b0, 4'b1000, 1'b1, 6'h05, 2'd0, 2'd1};
    vecs[21] = '{4'b0111, 1'b0, 4'b1000, 1'b1, 6'h35, 2'd3, 2'd1};
    vecs[22] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 6'h36, 2'd3, 2'd1};
    vecs[23] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 6'h37, 2'd3, 2'd0};
    vecs[24] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 6'h37, 2'd3, 2'd0};
    vecs[25] = '{4'b1011, 1'b1, 4'b0000, 1'b0, 6'h37, 2'd3, 2'd0};
    vecs[26] = '{4'b1011, 1'b0, 4'b0100, 1'b0, 6'h37, 2'd3, 2'd0};
    vecs[27] = '{4'b1011, 1'b0, 4'b0100, 1'b0, 6'h37, 2'd3, 2'd1};
    vecs[28] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 6'h24, 2'd2, 2'd1};
    vecs[29] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 6'h25, 2'd2, 2'd0};

    for (int r = 0; r < 30; r++) begin
      applyStimulus(vecs[r].empty, vecs[r].af);
      checkOutput("tbl_pop", r, 8'(pop), 8'(vecs[r].expPop));
      checkOutput("tbl_push", r, 8'(push), 8'(vecs[r].expPush));
      checkOutput("tbl_data", r, 8'(dataOut), 8'(vecs[r].expData));
      checkOutput("tbl_class", r, 8'(outClass), 8'(vecs[r].expClass));
      checkOutput("tbl_state", r, 8'(state), 8'(vecs[r].expState));
      advance();
    end

    // Only class 2 holds three words
    applyReset(1'b0);
    base[2] = 6'h10;
    left[2] = 3;
    autoEmpty = 1'b1;
    refreshEmpty();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput("c2_pop", k, 8'(pop), (k < 3) ? 8'h04 : 8'h00);
      checkOutput("c2_push", k, 8'(push), (k >= 2 && k <= 4) ? 8'h01 : 8'h00);
      if (k >= 2 && k <= 4) begin
        checkOutput("c2_data", k, 8'(dataOut), 8'h11 + 8'(k - 2));
        checkOutput("c2_class", k, 8'(outClass), 8'h02);
      end
      advance();
    end

    // Class 0 has one word, class 3 has three: pops 0,3,3,3 back to back
    applyReset(1'b0);
    left[0] = 1;
    left[3] = 3;
    autoEmpty = 1'b1;
    refreshEmpty();
    p5[0] = 4'b0001; p5[1] = 4'b1000; p5[2] = 4'b1000; p5[3] = 4'b1000;
    p5[4] = 4'b0000; p5[5] = 4'b0000; p5[6] = 4'b0000;
    d5[0] = 6'h01; d5[1] = 6'h31; d5[2] = 6'h32; d5[3] = 6'h33;
    c5[0] = 2'd0;  c5[1] = 2'd3;  c5[2] = 2'd3;  c5[3] = 2'd3;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput("c5_pop", k, 8'(pop), 8'(p5[k]));
      checkOutput("c5_push", k, 8'(push), (k >= 2 && k <= 5) ? 8'h01 : 8'h00);
      if (k >= 2 && k <= 5) begin
        checkOutput("c5_data", k, 8'(dataOut), 8'(d5[k-2]));
        checkOutput("c5_class", k, 8'(outClass), 8'(c5[k-2]));
      end
      advance();
    end

    // Reset one cycle after a class-1 pop in continuous flow
    applyReset(1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput("r6_pop", k, 8'(pop), (k < 2) ? 8'h01 : 8'h02);
      advance();
    end
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("r6_pop_rst", 3, 8'(pop), 8'h00);
    checkOutput("r6_push_rst", 3, 8'(push), 8'h01);
    checkOutput("r6_data_rst", 3, 8'(dataOut), 8'h02);
    advance();
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("r6_push", 4, 8'(push), 8'h00);
    checkOutput("r6_pop", 4, 8'(pop), 8'h01);
    checkOutput("r6_state", 4, 8'(state), 8'h00);
    checkOutput("r6_data", 4, 8'(dataOut), 8'h00);
    advance();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("r6_push", 5, 8'(push), 8'h00);
    checkOutput("r6_pop", 5, 8'(pop), 8'h01);
    advance();
    applyStimulus(4'b0000, 1'b0);
    checkOutput("r6_push", 6, 8'(push), 8'h01);
    checkOutput("r6_data", 6, 8'(dataOut), 8'h03);
    checkOutput("r6_class", 6, 8'(outClass), 8'h00);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
